// File: rtl/bus_interconnect.sv
// Data-port interconnect: decodes the core's OBI-style requests onto NUM_SLV slave slots,
// with per-slot handshaking, unmapped-address errors, response timeout and an error counter.
module bus_interconnect #(
    parameter int NUM_SLV     = 7,
    parameter int ADDR_W      = 14,
    parameter int SEL_LSB     = 6,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [3:0]              data_be_i,
    input  logic [ADDR_W-1:0]       data_addr_i,
    input  logic [31:0]             data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [31:0]             data_rdata_o,
    output logic                    data_err_o,
    output logic [7:0]              err_cnt_o,
    output logic [NUM_SLV-1:0]      slv_req_o,
    output logic                    slv_we_o,
    output logic [3:0]              slv_be_o,
    output logic [ADDR_W-2:0]       slv_addr_o,
    output logic [31:0]             slv_wdata_o,
    input  logic [NUM_SLV-1:0]      slv_gnt_i,
    input  logic [NUM_SLV-1:0]      slv_rvalid_i,
    input  logic [NUM_SLV*32-1:0]   slv_rdata_i
);

    localparam int SLOT_W = SEL_W + 1;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SLOT_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic [SLOT_W-1:0]  dec_slot;
    logic               mapped;
    logic [NUM_SLV-1:0] dec_onehot;
    logic               sel_rvalid;
    logic [31:0]        sel_rdata;
    logic               timeout_hit;

    assign slv_we_o    = data_we_i;
    assign slv_be_o    = data_be_i;
    assign slv_addr_o  = data_addr_i[ADDR_W-2:0];
    assign slv_wdata_o = data_wdata_i;

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;
    assign err_cnt_o     = err_cnt_q;

    always_comb begin
        dec_slot = '0;
        if (data_addr_i[ADDR_W-1]) begin
            dec_slot = SLOT_W'(data_addr_i[SEL_LSB+SEL_W-1:SEL_LSB]) + SLOT_W'(1);
        end
        mapped     = int'(dec_slot) < NUM_SLV;
        dec_onehot = '0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            dec_onehot[k] = (dec_slot == SLOT_W'(k));
            if (sel_q == SLOT_W'(k)) begin
                sel_rvalid = slv_rvalid_i[k];
                sel_rdata  = slv_rdata_i[32*k +: 32];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && ((cnt_q + CNT_W'(1)) == TO_LIMIT);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        err_cnt_d  = err_cnt_q;
        data_gnt_o = 1'b0;
        slv_req_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (mapped) begin
                    slv_req_o  = dec_onehot & {NUM_SLV{data_req_i}};
                    data_gnt_o = data_req_i & |(slv_gnt_i & dec_onehot);
                    if (data_gnt_o) begin
                        sel_d   = dec_slot;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end else begin
                    // Unmapped: the error response is issued right away and shows up while in ERR.
                    data_gnt_o = data_req_i;
                    if (data_req_i) begin
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                        state_d  = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                if (sel_rvalid) begin
                    rvalid_d = 1'b1;
                    rdata_d  = sel_rdata;
                    state_d  = ST_IDLE;
                end else if (timeout_hit) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    state_d  = ST_IDLE;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: a scoreboard queue holds the expected response
// (error flag, data, arrival cycle) pushed at grant time and checked when data_rvalid_o fires.
module tb_bus_interconnect;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          data_req_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [13:0]   data_addr_i;
    logic [31:0]   data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic          data_err_o;
    logic [7:0]    err_cnt_o;
    logic [6:0]    slv_req_o;
    logic          slv_we_o;
    logic [3:0]    slv_be_o;
    logic [12:0]   slv_addr_o;
    logic [31:0]   slv_wdata_o;
    logic [6:0]    slv_gnt_i;
    logic [6:0]    slv_rvalid_i;
    logic [223:0]  slv_rdata_i;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    logic [31:0] last_rdata = '0;

    bus_interconnect dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .err_cnt_o     (err_cnt_o),
        .slv_req_o     (slv_req_o),
        .slv_we_o      (slv_we_o),
        .slv_be_o      (slv_be_o),
        .slv_addr_o    (slv_addr_o),
        .slv_wdata_o   (slv_wdata_o),
        .slv_gnt_i     (slv_gnt_i),
        .slv_rvalid_i  (slv_rvalid_i),
        .slv_rdata_i   (slv_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every rvalid pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_i) begin
            last_rdata = '0;
            exp_cnt    = 0;
        end else if (data_rvalid_o) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_rvalid", 64'(1), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("rsp_err", 64'(data_err_o), 64'(mon_e.err));
                checkOutput("rsp_rdata", 64'(data_rdata_o), 64'(mon_e.rdata));
                checkOutput("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                if (mon_e.err && exp_cnt != 255) exp_cnt++;
                checkOutput("err_cnt", 64'(err_cnt_o), 64'(exp_cnt));
                last_rdata = mon_e.rdata;
            end
        end else begin
            checkOutput("rdata_hold", 64'(data_rdata_o), 64'(last_rdata));
            checkOutput("err_idle", 64'(data_err_o), 64'(0));
        end
    end

    // One master transaction; entered and left just after a rising edge.
    task automatic applyStimulus(input logic [13:0] addr, input logic we, input logic [31:0] wdata,
                                 input int gnt_wait, input int rsp_wait,
                                 input logic [31:0] rsp_data, input bit respond);
        int       slot;
        bit       mapped;
        int       g;
        exp_t     e;
        logic [6:0] exp_req;
        slot    = addr[13] ? 1 + int'(addr[8:6]) : 0;
        mapped  = slot < 7;
        exp_req = mapped ? (7'd1 << slot) : 7'd0;
        data_req_i   = 1'b1;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = we ? 4'b0011 : 4'b1111;
        data_wdata_i = wdata;
        slv_gnt_i    = ~exp_req;
        for (int i = 0; i < gnt_wait; i++) begin
            @(negedge clk_i);
            checkOutput("req_held", 64'(slv_req_o), 64'(exp_req));
            checkOutput("gnt_stalled", 64'(data_gnt_o), 64'(0));
            @(posedge clk_i); #1;
        end
        slv_gnt_i = exp_req;
        @(negedge clk_i);
        checkOutput("req_onehot", 64'(slv_req_o), 64'(exp_req));
        checkOutput("gnt", 64'(data_gnt_o), 64'(1));
        checkOutput("bcast_addr", 64'(slv_addr_o), 64'(addr[12:0]));
        checkOutput("bcast_we", 64'(slv_we_o), 64'(we));
        checkOutput("bcast_wdata", 64'(slv_wdata_o), 64'(wdata));
        checkOutput("bcast_be", 64'(slv_be_o), 64'(we ? 4'b0011 : 4'b1111));
        g = cyc;
        if (!mapped) begin
            e.err = 1'b1; e.rdata = '0; e.due = g + 1;
        end else if (respond) begin
            e.err = 1'b0; e.rdata = rsp_data; e.due = g + 2 + rsp_wait;
        end else begin
            e.err = 1'b1; e.rdata = '0; e.due = g + 17;
        end
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        slv_gnt_i = '1;
        if (mapped && respond && rsp_wait == 0) begin
            slv_rdata_i[slot*32 +: 32] = rsp_data;
            slv_rvalid_i[slot] = 1'b1;
        end
        @(negedge clk_i);
        checkOutput("busy_gnt", 64'(data_gnt_o), 64'(0));
        checkOutput("busy_req", 64'(slv_req_o), 64'(0));
        @(posedge clk_i); #1;
        data_req_i   = 1'b0;
        slv_gnt_i    = '0;
        slv_rvalid_i = '0;
        if (mapped && respond && rsp_wait > 0) begin
            repeat (rsp_wait - 1) begin
                @(posedge clk_i); #1;
            end
            slv_rdata_i[slot*32 +: 32] = rsp_data;
            slv_rvalid_i[slot] = 1'b1;
            @(posedge clk_i); #1;
            slv_rvalid_i = '0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb_q.size()), 64'(0));
            sb_q.delete();
        end
    endtask

    initial begin
        int          rs;
        logic [13:0] ra;
        rst_i        = 1'b1;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        slv_gnt_i    = '0;
        slv_rvalid_i = '0;
        for (int k = 0; k < 7; k++) slv_rdata_i[k*32 +: 32] = 32'hD00D_0000 + 32'(k);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_rvalid", 64'(data_rvalid_o), 64'(0));
        checkOutput("reset_err", 64'(data_err_o), 64'(0));
        checkOutput("reset_rdata", 64'(data_rdata_o), 64'(0));
        checkOutput("reset_err_cnt", 64'(err_cnt_o), 64'(0));
        checkOutput("reset_gnt", 64'(data_gnt_o), 64'(0));
        checkOutput("reset_req", 64'(slv_req_o), 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        applyStimulus(14'h0010, 1'b0, 32'h0, 0, 0, 32'hCAFEBABE, 1'b1);
        wait_drain();
        applyStimulus(14'h2140, 1'b1, 32'h1234_5678, 3, 2, 32'h0, 1'b1);
        wait_drain();
        applyStimulus(14'h21C0, 1'b0, 32'h0, 0, 0, 32'h0, 1'b1);
        wait_drain();

        // Slot 2 never answers; a late rvalid afterwards must be dropped.
        applyStimulus(14'h2040, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0);
        wait_drain();
        slv_rvalid_i[2] = 1'b1;
        @(posedge clk_i); #1;
        slv_rvalid_i = '0;
        @(negedge clk_i);
        checkOutput("late_ignored", 64'(data_rvalid_o), 64'(0));
        @(posedge clk_i); #1;

        applyStimulus(14'h2080, 1'b0, 32'h0, 0, 15, 32'h5A5A_0003, 1'b1);
        wait_drain();

        data_req_i  = 1'b1;
        data_addr_i = 14'h2000;
        data_we_i   = 1'b0;
        slv_gnt_i   = 7'b0000010;
        @(negedge clk_i);
        checkOutput("rst_gnt", 64'(data_gnt_o), 64'(1));
        @(posedge clk_i); #1;
        data_req_i = 1'b0;
        slv_gnt_i  = '0;
        rst_i      = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        slv_rdata_i[63:32] = 32'h0BAD_0BAD;
        slv_rvalid_i[1]    = 1'b1;
        @(negedge clk_i);
        checkOutput("rst_err_cnt", 64'(err_cnt_o), 64'(0));
        checkOutput("rst_no_rsp", 64'(data_rvalid_o), 64'(0));
        @(posedge clk_i); #1;
        slv_rvalid_i = '0;
        @(negedge clk_i);
        checkOutput("rst_no_rsp2", 64'(data_rvalid_o), 64'(0));
        @(posedge clk_i); #1;
        applyStimulus(14'h2000, 1'b0, 32'h0, 1, 1, 32'h600D_F00D, 1'b1);
        wait_drain();

        for (int i = 0; i < 8; i++) begin
            rs = $urandom_range(0, 6);
            ra = 14'($urandom);
            if (rs == 0) begin
                ra[13] = 1'b0;
            end else begin
                ra[13]  = 1'b1;
                ra[8:6] = 3'(rs - 1);
            end
            applyStimulus(ra, 1'($urandom), $urandom, $urandom_range(0, 3),
                          $urandom_range(0, 5), $urandom, 1'b1);
            wait_drain();
        end

        for (int i = 0; i < 300; i++) begin
            applyStimulus(14'h21C0, 1'b0, 32'h0, 0, 0, 32'h0, 1'b1);
            wait_drain();
        end
        @(negedge clk_i);
        checkOutput("sat_final", 64'(err_cnt_o), 64'(255));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
